// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues in-order instruction fetches under a credit limit,
// buffers responses for decode and squashes stale fetches on a redirect.
module fetch_pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  buf_cnt_q, buf_cnt_d;
  logic [PTR_W-1:0]  buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [PTR_W-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [XLEN-1:0]   tag_mem  [BUF_DEPTH];
  logic [31:0]       buf_data [BUF_DEPTH];
  logic [XLEN-1:0]   buf_pc   [BUF_DEPTH];

  logic              buf_pop, buf_push, accept, rsp_live, rsp_drop;
  logic [SUM_W-1:0]  credit_used;
  logic [CNT_W-1:0]  out_after, drop_after;

  // Handshakes and credit check; a same-cycle pop frees a credit immediately.
  always_comb begin
    instr_valid    = (buf_cnt_q != '0);
    buf_pop        = instr_valid && instr_ready;
    credit_used    = SUM_W'(out_q) + SUM_W'(drop_q) + SUM_W'(buf_cnt_q) - SUM_W'(buf_pop);
    imem_req_valid = (state_q == RUN) && (credit_used < SUM_W'(BUF_DEPTH));
    imem_req_addr  = fetch_pc_q;
    accept         = imem_req_valid && imem_req_ready;
    rsp_live       = imem_rsp_valid && (drop_q == '0);
    rsp_drop       = imem_rsp_valid && (drop_q != '0);
    buf_push       = rsp_live && !pc_src;
    instr_data     = buf_data[buf_rd_q];
    instr_pc       = buf_pc[buf_rd_q];
  end

  // Next-state logic: BOOT lasts one cycle, a redirect overrides PC and flushes the buffer.
  always_comb begin
    state_d    = RUN;
    fetch_pc_d = fetch_pc_q;
    buf_cnt_d  = buf_cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_wr_d   = buf_wr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    out_after  = out_q + CNT_W'(accept) - CNT_W'(rsp_live);
    drop_after = drop_q - CNT_W'(rsp_drop);
    out_d      = out_after;
    drop_d     = drop_after;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      tag_wr_d   = tag_wr_q + PTR_W'(1);
    end
    if (imem_rsp_valid) tag_rd_d = tag_rd_q + PTR_W'(1);

    if (buf_push) buf_wr_d = buf_wr_q + PTR_W'(1);
    if (buf_pop)  buf_rd_d = buf_rd_q + PTR_W'(1);
    buf_cnt_d = buf_cnt_q + CNT_W'(buf_push) - CNT_W'(buf_pop);

    if (pc_src) begin
      fetch_pc_d = pc_target & ~XLEN'(3);
      drop_d     = drop_after + out_after;
      out_d      = '0;
      buf_cnt_d  = '0;
      buf_rd_d   = '0;
      buf_wr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      buf_cnt_q  <= '0;
      buf_rd_q   <= '0;
      buf_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Tag FIFO holds the PC of every fetch still in flight, including ones to be dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_mem  <= '{default: '0};
      buf_data <= '{default: '0};
      buf_pc   <= '{default: '0};
    end else begin
      if (accept) tag_mem[tag_wr_q] <= fetch_pc_q;
      if (buf_push) begin
        buf_data[buf_wr_q] <= imem_rsp_data;
        buf_pc[buf_wr_q]   <= tag_mem[tag_rd_q];
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && !buf_pop && (buf_cnt_q == CNT_W'(BUF_DEPTH))));

endmodule
